sample_averager: RTL and testbench

- Downstream consumer of the 2 MHz read-control stage.
- Each cycle its `add` input is high, it accepts one sample word from the FIFO read port.
- It accumulates 2^LOG2_N consecutive accepted samples and computes their floor average.
- It writes each average into an output RAM at an auto-incrementing, wrapping address and flags each completed RAM pass.

---
 rtl/sample_averager_if.sv | 49 ++++
 rtl/sample_averager.sv | 129 ++++++++++++
 tb/tb_sample_averager.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sample_averager_if.sv
// ---------------------------------------------------------------------------
// sample_averager_if
// Bundles the signals between the read-control stage, the averager and the
// output RAM.
//
// Handshake: the averager never back-pressures. On every posedge where `add`
// is high, `data_in` is consumed. The RAM side is a pure strobe: `ram_addr`
// and `ram_data` are valid on exactly those cycles where `ram_wr_en` is high.
//
// Signals:
//   add        - sample-accept strobe (producer -> averager)
//   data_in    - unsigned sample, valid while add is high
//   clear      - synchronous flush of the partial group
//   ram_wr_en  - one-cycle RAM write strobe
//   ram_addr   - RAM write address
//   ram_data   - floor average of the completed group
//   sample_cnt - samples held in the current group
//   pass_done  - pulse on the write to the last RAM address
//   dbg_state  - FSM state (0 = ACCUM, 1 = WRITE)
//
// Modports:
//   master - the producer/observer side
//   slave  - the averager
// ---------------------------------------------------------------------------
interface sample_averager_if #(
   parameter int WIDTH  = 8,
   parameter int LOG2_N = 2,
   parameter int ADDR_W = 8
) ();
   logic              add;
   logic [WIDTH-1:0]  data_in;
   logic              clear;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [WIDTH-1:0]  ram_data;
   logic [LOG2_N-1:0] sample_cnt;
   logic              pass_done;
   logic              dbg_state;

   modport master (
      output add, data_in, clear,
      input  ram_wr_en, ram_addr, ram_data, sample_cnt, pass_done, dbg_state
   );

   modport slave (
      input  add, data_in, clear,
      output ram_wr_en, ram_addr, ram_data, sample_cnt, pass_done, dbg_state
   );
endinterface

// File: rtl/sample_averager.sv
// ---------------------------------------------------------------------------
// sample_averager
// Accumulates 2^LOG2_N consecutive accepted samples, writes their floor
// average to an output RAM at an auto-incrementing, wrapping address, and
// pulses pass_done on the write to the last address.
//
// Ports:
//   clk     - system clock, all state updates on posedge
//   reset_n - asynchronous active-low reset
//   bus     - sample_averager_if.slave (sample input, clear, RAM write side,
//             sample count, pass flag, FSM state)
// ---------------------------------------------------------------------------
module sample_averager #(
   parameter int WIDTH  = 8,
   parameter int LOG2_N = 2,
   parameter int ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sample_averager_if.slave     bus
);

   localparam int ACC_W = WIDTH + LOG2_N;
   localparam logic [LOG2_N-1:0] CNT_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ACC_W-1:0]  r_acc;
   logic [LOG2_N-1:0] r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [WIDTH-1:0]  r_data;

   logic [ACC_W-1:0]  w_sum;
   logic              w_take;
   logic              w_last;
   logic              w_wr_en;
   logic              w_pass;

   // Zero-extended add; ACC_W bits hold N full-scale samples without overflow.
   assign w_sum  = r_acc + {{LOG2_N{1'b0}}, bus.data_in};
   // clear wins over add, so a sample arriving with clear is dropped.
   assign w_take = bus.add && !bus.clear;
   assign w_last = w_take && (r_cnt == CNT_MAX);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and outputs
   // A group cannot complete during WRITE (the count restarts at 0 and
   // N >= 2), so WRITE always lasts exactly one cycle.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      w_pass       = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_last) begin
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_wr_en      = 1'b1;
            w_pass       = (r_addr == ADDR_MAX);
            w_state_next = w_last ? ST_WRITE : ST_ACCUM;
         end
         default: begin
            w_state_next = ST_ACCUM;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Accumulator datapath. Runs in both states so a sample accepted
   // during WRITE starts the next group.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
      end else if (bus.clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (bus.add) begin
         if (r_cnt == CNT_MAX) begin
            // Floor average: drop the LOG2_N low bits of the full sum.
            r_data <= w_sum[ACC_W-1:LOG2_N];
            r_acc  <= '0;
            r_cnt  <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LOG2_N'(1);
         end
      end
   end

   // Address advances after each write and wraps naturally at 2^ADDR_W.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
      end else if (r_state == ST_WRITE) begin
         r_addr <= r_addr + ADDR_W'(1);
      end
   end

   assign bus.ram_wr_en  = w_wr_en;
   assign bus.ram_addr   = r_addr;
   assign bus.ram_data   = r_data;
   assign bus.sample_cnt = r_cnt;
   assign bus.pass_done  = w_pass;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sample_averager.sv
module tb_sample_averager;

   logic clk;
   logic reset_n;
   logic add;
   logic [7:0] data_in;
   logic clear;

   int n_checks = 0;
   int n_errors = 0;

   // expected write: {pass_done, ram_addr, ram_data}
   logic [16:0] exp_a_q[$];   // ADDR_W = 8 instance
   logic [10:0] exp_b_q[$];   // ADDR_W = 2 instance

   sample_averager_if #(.WIDTH(8), .LOG2_N(2), .ADDR_W(8)) bus_a ();
   sample_averager_if #(.WIDTH(8), .LOG2_N(2), .ADDR_W(2)) bus_b ();

   assign bus_a.add     = add;
   assign bus_a.data_in = data_in;
   assign bus_a.clear   = clear;
   assign bus_b.add     = add;
   assign bus_b.data_in = data_in;
   assign bus_b.clear   = clear;

   sample_averager #(.WIDTH(8), .LOG2_N(2), .ADDR_W(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );
   sample_averager #(.WIDTH(8), .LOG2_N(2), .ADDR_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      add = 1'b0; clear = 1'b0; data_in = '0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] d);
      @(negedge clk);
      add = 1'b1; data_in = d; clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         add = 1'b0; clear = 1'b0;
      end
   endtask

   task automatic expect_wr(input logic [7:0] d, input logic [7:0] addr_a,
                            input logic [1:0] addr_b, input logic pass_b);
      exp_a_q.push_back({1'b0, addr_a, d});
      exp_b_q.push_back({pass_b, addr_b, d});
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (bus_a.ram_wr_en) begin
         if (exp_a_q.size() == 0) begin
            check("a_unexpected_write", 32'(bus_a.ram_addr), 32'hFFFF_FFFF);
         end else begin
            check("a_write", {15'd0, bus_a.pass_done, bus_a.ram_addr, bus_a.ram_data},
                  32'(exp_a_q.pop_front()));
         end
      end
      if (bus_b.ram_wr_en) begin
         if (exp_b_q.size() == 0) begin
            check("b_unexpected_write", 32'(bus_b.ram_addr), 32'hFFFF_FFFF);
         end else begin
            check("b_write", {21'd0, bus_b.pass_done, bus_b.ram_addr, bus_b.ram_data},
                  32'(exp_b_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] t6_avg  [5] = '{8'd2, 8'd12, 8'd22, 8'd32, 8'd42};
   logic [1:0] t6_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic       t6_pass [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      do_reset();
      check("rst_wr_en",  32'(bus_a.ram_wr_en),  0);
      check("rst_addr",   32'(bus_a.ram_addr),   0);
      check("rst_data",   32'(bus_a.ram_data),   0);
      check("rst_cnt",    32'(bus_a.sample_cnt), 0);
      check("rst_pass",   32'(bus_a.pass_done),  0);

      // group of four: (16+32+48+64)/4 = 40
      send(8'h10); send(8'h20);
      check("cnt_after_one", 32'(bus_a.sample_cnt), 1);
      send(8'h30);
      send(8'h40); expect_wr(8'h28, 8'd0, 2'd0, 1'b0);
      idle(1);
      check("latency_wr_en", 32'(bus_a.ram_wr_en), 1);
      idle(1);
      check("wr_en_one_cycle", 32'(bus_a.ram_wr_en), 0);
      check("addr_after_write", 32'(bus_a.ram_addr), 1);

      // saturation: 4*255/4 = 255
      for (int i = 0; i < 4; i++) send(8'hFF);
      expect_wr(8'hFF, 8'd1, 2'd1, 1'b0);
      idle(2);

      // floor: 5 >> 2 = 1
      send(8'd1); send(8'd1); send(8'd1); send(8'd2);
      expect_wr(8'h01, 8'd2, 2'd2, 1'b0);
      idle(2);

      // gapped: 40/4 = 10; small instance hits address 3 -> pass_done
      send(8'd4); idle(3);
      check("gap_cnt_hold1", 32'(bus_a.sample_cnt), 1);
      send(8'd8); send(8'd12); idle(5);
      check("gap_cnt_hold3", 32'(bus_a.sample_cnt), 3);
      send(8'd16); expect_wr(8'h0A, 8'd3, 2'd3, 1'b1);
      idle(2);

      // continuous 0..11: averages 1, 5, 9
      do_reset();
      for (int i = 0; i < 12; i++) begin
         send(8'(i));
         if (i == 3)  expect_wr(8'd1, 8'd0, 2'd0, 1'b0);
         if (i == 7)  expect_wr(8'd5, 8'd1, 2'd1, 1'b0);
         if (i == 11) expect_wr(8'd9, 8'd2, 2'd2, 1'b0);
      end
      idle(2);
      check("cont_addr", 32'(bus_a.ram_addr), 3);

      // address wrap: groups g*10+{1,2,3,4}
      do_reset();
      for (int g = 0; g < 5; g++) begin
         for (int k = 1; k <= 4; k++) send(8'(g * 10 + k));
         expect_wr(t6_avg[g], 8'(g), t6_addr[g], t6_pass[g]);
      end
      idle(2);
      check("wrap_addr_b", 32'(bus_b.ram_addr), 1);

      // clear together with add drops the sample
      send(8'd100); send(8'd100);
      @(negedge clk); add = 1'b1; data_in = 8'd200; clear = 1'b1;
      idle(1);
      check("clear_cnt", 32'(bus_a.sample_cnt), 0);
      for (int i = 0; i < 4; i++) send(8'd8);
      expect_wr(8'd8, 8'd5, 2'd1, 1'b0);
      idle(2);

      // clear during WRITE does not cancel the write
      for (int i = 0; i < 4; i++) send(8'd20);
      expect_wr(8'd20, 8'd6, 2'd2, 1'b0);
      @(negedge clk); add = 1'b0; clear = 1'b1;
      idle(2);
      check("data_holds", 32'(bus_a.ram_data), 20);

      // asynchronous reset mid-group
      send(8'd50); send(8'd50); send(8'd50);
      idle(1);
      check("pre_reset_cnt", 32'(bus_a.sample_cnt), 3);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_cnt",  32'(bus_a.sample_cnt), 0);
      check("async_rst_data", 32'(bus_a.ram_data),   0);
      check("async_rst_addr", 32'(bus_a.ram_addr),   0);
      check("async_rst_wr",   32'(bus_a.ram_wr_en),  0);
      @(negedge clk); reset_n = 1'b1;
      send(8'd4); send(8'd4); send(8'd4); send(8'd8);
      expect_wr(8'd5, 8'd0, 2'd0, 1'b0);
      idle(3);

      check("a_queue_drained", 32'(exp_a_q.size()), 0);
      check("b_queue_drained", 32'(exp_b_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
